// File: rtl/filter_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module   : filter_ctrl_pkg
// Brief    : Types and default settings for the filter pulse controller.
// Revision : 1.0 - initial release
//==============================================================================
package filter_ctrl_pkg;

    import package_settings::SIZE_FILTER_DATA;

    localparam int DEF_SIZE_FILTER_DATA = SIZE_FILTER_DATA;
    localparam int DEF_SETTLE_CYCLES    = 17;
    localparam int DEF_DEAD_TIME        = 16;
    localparam int DEF_MAX_PULSE_LEN    = 64;
    localparam int DEF_TS_WIDTH         = 32;
    localparam int DEF_DROP_WIDTH       = 16;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        ARMED = 2'd1,
        PEAK  = 2'd2,
        DEAD  = 2'd3
    } fpc_state_t;

    // Field order matches the packed payload carried by event_slot.
    typedef struct packed {
        logic [DEF_SIZE_FILTER_DATA-1:0] amplitude;
        logic [DEF_TS_WIDTH-1:0]         timestamp;
        logic                            pileup;
    } pulse_event_t;

endpackage : filter_ctrl_pkg
`default_nettype wire

// File: rtl/package_settings.sv
`default_nettype none
//==============================================================================
// Module   : package_settings
// Brief    : Shared data-path settings for the pulse-processing chain.
// Revision : 1.0 - initial release
//==============================================================================
package package_settings;

    localparam int SIZE_FILTER_DATA = 16;

endpackage : package_settings
`default_nettype wire

// File: rtl/filter_pulse_controller_event_slot.sv
`default_nettype none
//==============================================================================
// Module   : event_slot
// Brief    : Single-entry valid/ready event register with saturating drop count.
// Revision : 1.0 - initial release
//==============================================================================
module event_slot #(
    parameter int DATA_W     = 49,
    parameter int DROP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DATA_W-1:0]     i_data,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_W-1:0]     o_data,
    output logic [DROP_WIDTH-1:0] o_drop_count
);

    logic                  r_valid;
    logic [DATA_W-1:0]     r_data;
    logic [DROP_WIDTH-1:0] r_drop;

    // A load is accepted when the slot is empty or is being drained this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_drop  <= '0;
        end else if (i_load) begin
            if (!r_valid || i_ready) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
            end else if (r_drop != '1) begin
                r_drop <= r_drop + DROP_WIDTH'(1);
            end
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid      = r_valid;
    assign o_data       = r_data;
    assign o_drop_count = r_drop;

endmodule : event_slot
`default_nettype wire

// File: rtl/filter_pulse_controller.sv
`default_nettype none
//==============================================================================
// Module   : filter_pulse_controller
// Brief    : Flushes a shaping filter, detects pulses and emits peak events.
// Revision : 1.0 - initial release
//==============================================================================
module filter_pulse_controller
    import filter_ctrl_pkg::*;
#(
    parameter int SIZE_FILTER_DATA = DEF_SIZE_FILTER_DATA,
    parameter int SETTLE_CYCLES    = DEF_SETTLE_CYCLES,
    parameter int DEAD_TIME        = DEF_DEAD_TIME,
    parameter int MAX_PULSE_LEN    = DEF_MAX_PULSE_LEN,
    parameter int TS_WIDTH         = DEF_TS_WIDTH,
    parameter int DROP_WIDTH       = DEF_DROP_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [SIZE_FILTER_DATA-1:0] threshold,
    input  logic [SIZE_FILTER_DATA-1:0] filter_data,
    output logic                        filter_reset,
    output logic [SIZE_FILTER_DATA-1:0] event_amplitude,
    output logic [TS_WIDTH-1:0]         event_time,
    output logic                        event_pileup,
    output logic                        event_valid,
    input  logic                        event_ready,
    output logic [DROP_WIDTH-1:0]       drop_count,
    output logic                        busy
);

    localparam int FLUSH_W = $clog2(SETTLE_CYCLES + 1);
    localparam int DEAD_W  = $clog2(DEAD_TIME + 1);
    localparam int LEN_W   = $clog2(MAX_PULSE_LEN + 1);
    localparam int EVT_W   = SIZE_FILTER_DATA + TS_WIDTH + 1;

    localparam logic [FLUSH_W-1:0] c_settle      = FLUSH_W'(SETTLE_CYCLES);
    localparam logic [FLUSH_W-1:0] c_settle_last = FLUSH_W'(SETTLE_CYCLES - 1);
    localparam logic [DEAD_W-1:0]  c_dead_last   = DEAD_W'(DEAD_TIME - 1);
    localparam logic [LEN_W-1:0]   c_max_len     = LEN_W'(MAX_PULSE_LEN);

    fpc_state_t                  r_state;
    logic [FLUSH_W-1:0]          r_flush_cnt;
    logic [DEAD_W-1:0]           r_dead_cnt;
    logic [LEN_W-1:0]            r_len_cnt;
    logic [SIZE_FILTER_DATA-1:0] r_peak;
    logic [TS_WIDTH-1:0]         r_time;
    logic [TS_WIDTH-1:0]         r_ts;
    logic                        r_filter_reset;

    logic                        w_below;
    logic                        w_len_hit;
    logic                        w_emit;
    logic                        w_pileup;
    logic [EVT_W-1:0]            w_evt_in;
    logic [EVT_W-1:0]            w_evt_out;

    assign w_below   = (filter_data <= threshold);
    assign w_len_hit = (r_len_cnt == c_max_len);
    // The terminating sample is handed to the slot on its own edge: 1-clk latency.
    assign w_emit    = enable && (r_state == PEAK) && (w_below || w_len_hit);
    assign w_pileup  = !w_below;
    assign w_evt_in  = {r_peak, r_time, w_pileup};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= FLUSH;
            r_flush_cnt    <= '0;
            r_dead_cnt     <= '0;
            r_len_cnt      <= '0;
            r_peak         <= '0;
            r_time         <= '0;
            r_filter_reset <= 1'b0;
        end else if (!enable) begin
            r_state        <= FLUSH;
            r_flush_cnt    <= '0;
            r_filter_reset <= 1'b0;
        end else begin
            case (r_state)
                FLUSH: begin
                    if (r_flush_cnt == c_settle) begin
                        r_state <= ARMED;
                    end else begin
                        r_flush_cnt    <= r_flush_cnt + FLUSH_W'(1);
                        r_filter_reset <= (r_flush_cnt == c_settle_last);
                    end
                end
                ARMED: begin
                    if (!w_below) begin
                        r_state   <= PEAK;
                        r_peak    <= filter_data;
                        r_time    <= r_ts;
                        r_len_cnt <= LEN_W'(1);
                    end
                end
                PEAK: begin
                    if (w_below || w_len_hit) begin
                        r_state    <= DEAD;
                        r_dead_cnt <= '0;
                    end else begin
                        // Strict compare keeps the first of equal maxima.
                        if (filter_data > r_peak) begin
                            r_peak <= filter_data;
                        end
                        r_len_cnt <= r_len_cnt + LEN_W'(1);
                    end
                end
                DEAD: begin
                    if (r_dead_cnt != c_dead_last) begin
                        r_dead_cnt <= r_dead_cnt + DEAD_W'(1);
                    end else if (w_below) begin
                        r_state <= ARMED;
                    end
                end
                default: begin
                    r_state <= FLUSH;
                end
            endcase
        end
    end

    event_slot #(
        .DATA_W     (EVT_W),
        .DROP_WIDTH (DROP_WIDTH)
    ) u_event_slot (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_emit),
        .i_data       (w_evt_in),
        .i_ready      (event_ready),
        .o_valid      (event_valid),
        .o_data       (w_evt_out),
        .o_drop_count (drop_count)
    );

    assign event_amplitude = w_evt_out[EVT_W-1 -: SIZE_FILTER_DATA];
    assign event_time      = w_evt_out[TS_WIDTH:1];
    assign event_pileup    = w_evt_out[0];
    assign filter_reset    = r_filter_reset;
    assign busy            = (r_state != ARMED);

endmodule : filter_pulse_controller
`default_nettype wire

// File: tb/tb_filter_pulse_controller.sv
`default_nettype none
//==============================================================================
// Module   : tb_filter_pulse_controller
// Brief    : Table, directed and randomized checks of filter_pulse_controller.
// Revision : 1.0 - initial release
//==============================================================================
module tb_filter_pulse_controller;

    localparam int DW     = 16;
    localparam int TSW    = 32;
    localparam int DRW    = 16;
    localparam int SETTLE = 17;
    localparam int DEADT  = 16;
    localparam int MAXLEN = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic           event_ready;
    logic [DW-1:0]  threshold;
    logic [DW-1:0]  filter_data;
    logic           filter_reset;
    logic [DW-1:0]  event_amplitude;
    logic [TSW-1:0] event_time;
    logic           event_pileup;
    logic           event_valid;
    logic [DRW-1:0] drop_count;
    logic           busy;

    always #5 clk = ~clk;

    filter_pulse_controller #(
        .SIZE_FILTER_DATA (DW),
        .SETTLE_CYCLES    (SETTLE),
        .DEAD_TIME        (DEADT),
        .MAX_PULSE_LEN    (MAXLEN),
        .TS_WIDTH         (TSW),
        .DROP_WIDTH       (DRW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .threshold       (threshold),
        .filter_data     (filter_data),
        .filter_reset    (filter_reset),
        .event_amplitude (event_amplitude),
        .event_time      (event_time),
        .event_pileup    (event_pileup),
        .event_valid     (event_valid),
        .event_ready     (event_ready),
        .drop_count      (drop_count),
        .busy            (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: settle countdown, pulse tracking, holdoff and one-slot queue.
    int             m_settle_left;
    bit             m_live;
    bit             m_in_pulse;
    bit             m_dead;
    int             m_holdoff;
    int             m_samples;
    logic [DW-1:0]  m_peak;
    logic [TSW-1:0] m_start;
    logic [TSW-1:0] m_ts;
    bit             m_valid;
    logic [DW-1:0]  m_amp;
    logic [TSW-1:0] m_time;
    bit             m_pile;
    int             m_drops;

    task automatic model_reset();
        m_settle_left = SETTLE;
        m_live = 0; m_in_pulse = 0; m_dead = 0;
        m_holdoff = 0; m_samples = 0;
        m_peak = '0; m_start = '0; m_ts = '0;
        m_valid = 0; m_amp = '0; m_time = '0; m_pile = 0; m_drops = 0;
    endtask

    task automatic model_edge(input bit en, input logic [DW-1:0] thr, input logic [DW-1:0] d, input bit rdy);
        bit             emit;
        bit             pile;
        logic [DW-1:0]  ev_amp;
        logic [TSW-1:0] ev_time;
        emit = 0; pile = 0; ev_amp = '0; ev_time = '0;
        if (!en) begin
            m_settle_left = SETTLE;
            m_live = 0; m_in_pulse = 0; m_dead = 0;
        end else if (m_settle_left > 0) begin
            m_settle_left--;
        end else if (!m_live) begin
            m_live = 1;
        end else if (m_in_pulse) begin
            if (d <= thr || m_samples == MAXLEN) begin
                emit = 1; pile = (d > thr); ev_amp = m_peak; ev_time = m_start;
                m_in_pulse = 0; m_dead = 1; m_holdoff = DEADT;
            end else begin
                if (d > m_peak) m_peak = d;
                m_samples++;
            end
        end else if (m_dead) begin
            if (m_holdoff > 0) m_holdoff--;
            if (m_holdoff == 0 && d <= thr) m_dead = 0;
        end else if (d > thr) begin
            m_in_pulse = 1; m_peak = d; m_start = m_ts; m_samples = 1;
        end
        if (emit) begin
            if (!m_valid || rdy) begin
                m_valid = 1; m_amp = ev_amp; m_time = ev_time; m_pile = pile;
            end else if (m_drops < (1 << DRW) - 1) begin
                m_drops++;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_ts = m_ts + 1;
    endtask

    task automatic check_model();
        check("filter_reset", 64'(filter_reset), 64'(m_settle_left == 0));
        check("busy", 64'(busy), 64'(!(m_live && !m_in_pulse && !m_dead)));
        check("event_valid", 64'(event_valid), 64'(m_valid));
        check("drop_count", 64'(drop_count), 64'(m_drops));
        if (m_valid) begin
            check("event_amplitude", 64'(event_amplitude), 64'(m_amp));
            check("event_time", 64'(event_time), 64'(m_time));
            check("event_pileup", 64'(event_pileup), 64'(m_pile));
        end
    endtask

    task automatic step(input bit en, input logic [DW-1:0] thr, input logic [DW-1:0] d, input bit rdy);
        enable = en; threshold = thr; filter_data = d; event_ready = rdy;
        @(posedge clk);
        model_edge(en, thr, d, rdy);
        cyc++;
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic [DW-1:0] data;
        bit            rdy;
        bit            valid;
        logic [DW-1:0] amp;
        bit            pile;
        bit            busy;
    } vec_t;

    initial begin
        vec_t          tbl [6];
        int            fr_rise;
        int            busy_fall;
        int            vrise;
        int            t_cross;
        bit            hi;
        bit            en_r;
        logic [DW-1:0] thr_r;
        logic [DW-1:0] d_r;

        tbl[0] = '{16'd50,  1'b1, 1'b0, 16'd0,   1'b0, 1'b0};
        tbl[1] = '{16'd150, 1'b1, 1'b0, 16'd0,   1'b0, 1'b1};
        tbl[2] = '{16'd300, 1'b1, 1'b0, 16'd0,   1'b0, 1'b1};
        tbl[3] = '{16'd280, 1'b1, 1'b0, 16'd0,   1'b0, 1'b1};
        tbl[4] = '{16'd90,  1'b1, 1'b1, 16'd300, 1'b0, 1'b1};
        tbl[5] = '{16'd40,  1'b1, 1'b0, 16'd0,   1'b0, 1'b1};

        reset = 1'b0; enable = 1'b0; threshold = '0; filter_data = '0; event_ready = 1'b0;
        model_reset();
        #2;
        check("rst_filter_reset", 64'(filter_reset), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_valid", 64'(event_valid), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        @(negedge clk);
        reset = 1'b1; cyc = 0;

        // Flush after reset release.
        fr_rise = -1; busy_fall = -1;
        for (int i = 0; i < 20; i++) begin
            if (fr_rise < 0 && filter_reset) fr_rise = i;
            if (busy_fall < 0 && !busy) busy_fall = i;
            check("settle_valid", 64'(event_valid), 64'd0);
            step(1'b1, 16'd100, 16'd0, 1'b1);
        end
        check("settle_fr_low_clks", 64'(fr_rise), 64'd17);
        check("settle_busy_fall", 64'(busy_fall), 64'd18);

        // Ramp table.
        t_cross = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) t_cross = cyc;
            step(1'b1, 16'd100, tbl[i].data, tbl[i].rdy);
            check("tbl_valid", 64'(event_valid), 64'(tbl[i].valid));
            check("tbl_busy", 64'(busy), 64'(tbl[i].busy));
            if (tbl[i].valid) begin
                check("tbl_amp", 64'(event_amplitude), 64'(tbl[i].amp));
                check("tbl_pile", 64'(event_pileup), 64'(tbl[i].pile));
                check("tbl_time", 64'(event_time), 64'(t_cross));
            end
        end
        repeat (20) step(1'b1, 16'd100, 16'd0, 1'b1);

        // Long pulse forced out at the length limit, then held in dead time.
        vrise = -1;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 16'd100, 16'd500, 1'b1);
            if (event_valid && vrise < 0) begin
                vrise = i;
                check("pile_amp", 64'(event_amplitude), 64'd500);
                check("pile_flag", 64'(event_pileup), 64'd1);
            end
        end
        check("pile_emit_index", 64'(vrise), 64'd64);
        check("pile_tail_busy", 64'(busy), 64'd1);
        step(1'b1, 16'd100, 16'd50, 1'b1);
        check("pile_rearm", 64'(busy), 64'd0);
        step(1'b1, 16'd100, 16'd500, 1'b1);
        step(1'b1, 16'd100, 16'd50, 1'b1);
        check("pile_next_valid", 64'(event_valid), 64'd1);
        check("pile_next_flag", 64'(event_pileup), 64'd0);
        repeat (20) step(1'b1, 16'd100, 16'd10, 1'b1);

        // Back-pressure: first event held, second dropped.
        step(1'b1, 16'd100, 16'd200, 1'b0);
        step(1'b1, 16'd100, 16'd250, 1'b0);
        step(1'b1, 16'd100, 16'd50, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'd100, 16'd10, 1'b0);
            check("hold_amp", 64'(event_amplitude), 64'd250);
        end
        step(1'b1, 16'd100, 16'd300, 1'b0);
        step(1'b1, 16'd100, 16'd50, 1'b0);
        check("drop_one", 64'(drop_count), 64'd1);
        check("drop_kept_amp", 64'(event_amplitude), 64'd250);
        step(1'b1, 16'd100, 16'd10, 1'b1);
        check("drop_drained", 64'(event_valid), 64'd0);
        repeat (20) step(1'b1, 16'd100, 16'd10, 1'b1);

        // Enable drop mid-pulse with an event pending.
        step(1'b1, 16'd100, 16'd400, 1'b0);
        step(1'b1, 16'd100, 16'd30, 1'b0);
        repeat (20) step(1'b1, 16'd100, 16'd0, 1'b0);
        step(1'b1, 16'd100, 16'd600, 1'b0);
        step(1'b1, 16'd100, 16'd700, 1'b0);
        step(1'b0, 16'd100, 16'd700, 1'b0);
        check("dis_busy", 64'(busy), 64'd1);
        fr_rise = -1;
        for (int i = 0; i < 20; i++) begin
            if (fr_rise < 0 && filter_reset) fr_rise = i;
            step(1'b1, 16'd100, 16'd0, 1'b0);
        end
        check("dis_fr_low_clks", 64'(fr_rise), 64'd17);
        check("dis_pending_valid", 64'(event_valid), 64'd1);
        check("dis_pending_amp", 64'(event_amplitude), 64'd400);
        step(1'b1, 16'd100, 16'd0, 1'b1);
        check("dis_delivered", 64'(event_valid), 64'd0);

        // Asynchronous reset mid-pulse with an event pending.
        step(1'b1, 16'd100, 16'd300, 1'b0);
        step(1'b1, 16'd100, 16'd50, 1'b0);
        repeat (20) step(1'b1, 16'd100, 16'd0, 1'b0);
        step(1'b1, 16'd100, 16'd800, 1'b0);
        check("pre_rst_valid", 64'(event_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", 64'(event_valid), 64'd0);
        check("arst_amp", 64'(event_amplitude), 64'd0);
        check("arst_time", 64'(event_time), 64'd0);
        check("arst_pile", 64'(event_pileup), 64'd0);
        check("arst_drop", 64'(drop_count), 64'd0);
        check("arst_fr", 64'(filter_reset), 64'd0);
        check("arst_busy", 64'(busy), 64'd1);
        @(negedge clk);
        model_reset();
        reset = 1'b1; cyc = 0;

        // Ready raised on the very edge that emits into an occupied slot.
        repeat (20) step(1'b1, 16'd100, 16'd0, 1'b0);
        step(1'b1, 16'd100, 16'd200, 1'b0);
        step(1'b1, 16'd100, 16'd60, 1'b0);
        repeat (20) step(1'b1, 16'd100, 16'd0, 1'b0);
        t_cross = cyc;
        step(1'b1, 16'd100, 16'd900, 1'b0);
        step(1'b1, 16'd100, 16'd60, 1'b1);
        check("reload_valid", 64'(event_valid), 64'd1);
        check("reload_amp", 64'(event_amplitude), 64'd900);
        check("reload_time", 64'(event_time), 64'(t_cross));
        check("reload_drop", 64'(drop_count), 64'd0);
        step(1'b1, 16'd100, 16'd0, 1'b1);

        // Randomized traffic against the model.
        hi = 0; thr_r = 16'd100;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) hi = !hi;
            if ($urandom_range(0, 49) == 0) thr_r = 16'($urandom_range(50, 400));
            d_r  = hi ? 16'(32'(thr_r) + 1 + $urandom_range(0, 300)) : 16'($urandom_range(0, 32'(thr_r)));
            en_r = ($urandom_range(0, 299) != 0);
            step(en_r, thr_r, d_r, ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_filter_pulse_controller
`default_nettype wire
